// File: rtl/alu_hazard_scoreboard.sv
// Issue-side hazard scoreboard for the pipelined ALU: tracks in-flight destinations,
// stalls issue on unresolved RAW dependences, drives forward selects and tags writeback.
module alu_hazard_scoreboard #(
    parameter int LATENCY = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic             issue_use_rs1,
    input  logic             issue_use_rs2,
    output logic             issue_ready,
    input  logic             flush,
    output logic             fwd1_sel,
    output logic             fwd2_sel,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [LATENCY:1] v_q;
    logic [LATENCY:1] v_d;
    logic [4:0]       rd_q [1:LATENCY];
    logic [4:0]       rd_d [1:LATENCY];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic near1_s;
    logic near2_s;
    logic far1_s;
    logic far2_s;
    logic accept_s;
    logic stall_s;

    function automatic logic stage_match(input logic       v,
                                         input logic [4:0] rd,
                                         input logic [4:0] rs,
                                         input logic       use_rs);
        return v && (rd != 5'd0) && (rd == rs) && use_rs;
    endfunction

    // Classify each operand: producer still inside the ALU (near) or on ALUOut now (far)
    always_comb begin
        near1_s = 1'b0;
        near2_s = 1'b0;
        for (int k = 1; k < LATENCY; k++) begin
            near1_s = near1_s | stage_match(v_q[k], rd_q[k], issue_rs1, issue_use_rs1);
            near2_s = near2_s | stage_match(v_q[k], rd_q[k], issue_rs2, issue_use_rs2);
        end
        far1_s = stage_match(v_q[LATENCY], rd_q[LATENCY], issue_rs1, issue_use_rs1);
        far2_s = stage_match(v_q[LATENCY], rd_q[LATENCY], issue_rs2, issue_use_rs2);
    end

    // A near match always shadows an older result sitting on ALUOut
    assign issue_ready = !rst && !flush && !near1_s && !near2_s;
    assign fwd1_sel    = issue_valid && !rst && !near1_s && far1_s;
    assign fwd2_sel    = issue_valid && !rst && !near2_s && far2_s;
    assign accept_s    = issue_valid && issue_ready;
    assign stall_s     = issue_valid && !issue_ready && !flush && !rst;

    assign wb_valid  = !rst && v_q[LATENCY] && (rd_q[LATENCY] != 5'd0);
    assign wb_rd     = (!rst && v_q[LATENCY]) ? rd_q[LATENCY] : 5'd0;
    assign stall_cnt = stall_cnt_q;

    // Advance the tracking pipeline and the saturating stall counter
    always_comb begin
        v_d         = {LATENCY{1'b0}};
        stall_cnt_d = stall_cnt_q;
        for (int k = 1; k <= LATENCY; k++) begin
            rd_d[k] = 5'd0;
        end
        v_d[1]  = accept_s;
        rd_d[1] = accept_s ? issue_rd : 5'd0;
        for (int k = 2; k <= LATENCY; k++) begin
            v_d[k]  = v_q[k-1] && !flush;
            rd_d[k] = rd_q[k-1];
        end
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= {LATENCY{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            for (int k = 1; k <= LATENCY; k++) begin
                rd_q[k] <= 5'd0;
            end
        end else begin
            v_q         <= v_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 1; k <= LATENCY; k++) begin
                rd_q[k] <= rd_d[k];
            end
        end
    end

endmodule

// File: tb/tb_alu_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against an age-based
// in-flight operation model of the scoreboard.
module tb_alu_hazard_scoreboard;

    localparam int L  = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [4:0]    issue_rs1;
    logic [4:0]    issue_rs2;
    logic          issue_use_rs1;
    logic          issue_use_rs2;
    logic          issue_ready;
    logic          flush;
    logic          fwd1_sel;
    logic          fwd2_sel;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    alu_hazard_scoreboard #(.LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_ready(issue_ready), .flush(flush),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_cnt(stall_cnt)
    );

    // Reference model: list of operations in flight, each with its age in cycles
    typedef struct {
        int         age;
        logic [4:0] rd;
    } op_t;

    op_t        inflight[$];
    int         m_stall;
    int         checks = 0;
    int         errors = 0;
    logic       m_rdy, m_f1, m_f2, m_wv, m_acc;
    logic [4:0] m_wr;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void model_eval();
        bit n1 = 1'b0;
        bit n2 = 1'b0;
        bit l1 = 1'b0;
        bit l2 = 1'b0;
        m_wv = 1'b0;
        m_wr = 5'd0;
        foreach (inflight[i]) begin
            if (inflight[i].rd != 5'd0) begin
                if (issue_use_rs1 && inflight[i].rd == issue_rs1) begin
                    if (inflight[i].age < L) n1 = 1'b1; else l1 = 1'b1;
                end
                if (issue_use_rs2 && inflight[i].rd == issue_rs2) begin
                    if (inflight[i].age < L) n2 = 1'b1; else l2 = 1'b1;
                end
            end
            if (inflight[i].age == L && !rst) begin
                m_wv = (inflight[i].rd != 5'd0);
                m_wr = inflight[i].rd;
            end
        end
        m_rdy = !rst && !flush && !n1 && !n2;
        m_f1  = issue_valid && !rst && !n1 && l1;
        m_f2  = issue_valid && !rst && !n2 && l2;
        m_acc = issue_valid && m_rdy;
    endfunction

    function automatic void model_advance();
        if (rst) begin
            inflight.delete();
            m_stall = 0;
            return;
        end
        if (issue_valid && !m_rdy && !flush && m_stall < (1 << CW) - 1) m_stall++;
        foreach (inflight[i]) inflight[i].age++;
        while (inflight.size() > 0 && inflight[0].age > L) void'(inflight.pop_front());
        if (flush) inflight.delete();
        if (m_acc) inflight.push_back('{age: 1, rd: issue_rd});
    endfunction

    task automatic cycle();
        @(negedge clk);
        model_eval();
        chk("issue_ready", 8'(issue_ready), 8'(m_rdy));
        chk("fwd1_sel",    8'(fwd1_sel),    8'(m_f1));
        chk("fwd2_sel",    8'(fwd2_sel),    8'(m_f2));
        chk("wb_valid",    8'(wb_valid),    8'(m_wv));
        chk("wb_rd",       8'(wb_rd),       8'(m_wr));
        chk("stall_cnt",   8'(stall_cnt),   8'(m_stall));
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2);
        issue_valid   = v;
        issue_rd      = rd;
        issue_rs1     = rs1;
        issue_rs2     = rs2;
        issue_use_rs1 = u1;
        issue_use_rs2 = u2;
        flush         = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
        drive(1'b1, rd, rs1, rs2, u1, u2);
        cycle();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic issue_until_accepted(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic u1, input logic u2);
        int n = 0;
        drive(1'b1, rd, rs1, rs2, u1, u2);
        do begin
            cycle();
            n++;
        end while (!m_acc && n < 10);
        if (!m_acc) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout observed=%0d cycles expected=accept", n);
        end
    endtask

    initial begin
        logic hold;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        inflight.delete();
        m_stall = 0;
        cycle();

        // Independent stream
        issue(5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        idle(5);
        chk("indep_stall_cnt", 8'(stall_cnt), 8'd0);

        // Back-to-back RAW
        do_reset();
        issue(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        issue_until_accepted(5'd8, 5'd5, 5'd0, 1'b1, 1'b0);
        chk("raw_stall_cnt", 8'(stall_cnt), 8'd2);
        idle(4);

        // x0 producer and unused operand
        do_reset();
        issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(5'd2, 5'd0, 5'd0, 1'b1, 1'b0);
        idle(4);
        issue(5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(5'd9, 5'd0, 5'd7, 1'b0, 1'b0);
        idle(4);
        chk("x0_stall_cnt", 8'(stall_cnt), 8'd0);

        // Youngest producer wins
        do_reset();
        issue(5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        idle(1);
        issue(5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        issue_until_accepted(5'd10, 5'd4, 5'd0, 1'b1, 1'b0);
        chk("young_stall_cnt", 8'(stall_cnt), 8'd2);
        idle(3);

        // Flush kills in-flight producers
        do_reset();
        issue(5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
        issue(5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        flush = 1'b1;
        cycle();
        issue(5'd11, 5'd6, 5'd0, 1'b1, 1'b0);
        idle(3);

        // Reset mid-flight
        do_reset();
        issue(5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 5'd12, 5'd9, 5'd0, 1'b1, 1'b0);
        rst = 1'b1;
        cycle();
        idle(5);

        // Saturating stall counter through a long dependent chain
        do_reset();
        issue(5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (12) issue_until_accepted(5'd3, 5'd3, 5'd3, 1'b1, 1'b1);
        chk("sat_stall_cnt", 8'(stall_cnt), 8'd15);

        // Random traffic; stalled operations keep their fields stable
        do_reset();
        for (int i = 0; i < 400; i++) begin
            hold  = issue_valid && !m_acc && !rst && !flush;
            rst   = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 6);
            if (!hold) begin
                issue_valid   = ($urandom_range(0, 99) < 70);
                issue_rd      = 5'($urandom_range(0, 7));
                issue_rs1     = 5'($urandom_range(0, 7));
                issue_rs2     = 5'($urandom_range(0, 7));
                issue_use_rs1 = 1'($urandom_range(0, 1));
                issue_use_rs2 = 1'($urandom_range(0, 1));
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_hazard_scoreboard.md
# alu_hazard_scoreboard

Issue-side controller for the 3-stage pipelined ALU (operands registered twice, result registered once). It tracks every operation in flight with its destination register and produces the forwarding selects that steer the ALU operand muxes to the fresh result. It stalls the issue stage when an operand depends on a result that is not yet on the ALU output, and tags the ALU output with a writeback valid and destination. It sits between decode/issue and the ALU, and replaces ad-hoc hazard logic in the core.

## Interface
- LATENCY, 3, cycles from operation acceptance to result on ALUOut; legal range 2–6
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode presents an ALU operation
- issue_rd  in  5  destination register; 0 means no writeback
- issue_rs1 / issue_rs2  in  5  source registers
- issue_use_rs1 / issue_use_rs2  in  1  operand actually read from the register file
- issue_ready  out  1  operation accepted this cycle when issue_valid && issue_ready
- flush  in  1  kill all in-flight operations (branch taken / trap)
- fwd1_sel / fwd2_sel  out  1  drive the ALU operand-1/2 forward selects: use the ALU result
- wb_valid  out  1  ALUOut this cycle belongs to a live operation with rd≠0
- wb_rd  out  5  destination of that result
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Tracking shift register, stages k=1..LATENCY. Each stage holds {v, rd}. Stage k holds the operation accepted k cycles ago. Every cycle, stage k+1 ← stage k. Stage 1 ← {1, issue_rd} on accept; otherwise {0, 0} (a bubble).
- A stage matches a source register when v=1, rd≠0, rd==rs, and the corresponding use bit is 1. Register x0 never creates a hazard.
- Operand hazard (per operand):
  - youngest match in stages 1..LATENCY-1 → not ready;
  - otherwise a match in stage LATENCY → forward; fwdN_sel=1, combinational, same cycle;
  - otherwise no match → fwdN_sel=0.
- issue_ready = !rst && !flush && neither operand is "not ready". fwdN_sel is only meaningful when an operation is accepted; it is forced to 0 when issue_valid=0.
- Stall cycle: issue_valid=1 && issue_ready=0 && !flush && !rst. stall_cnt increments on each stall cycle and saturates at all-ones.
- wb_valid = stage LATENCY v && rd≠0; wb_rd = stage LATENCY rd (0 when v=0).
- flush: on the clock edge, all stage v bits clear. The current issue is not accepted (issue_ready=0). The wb outputs in the flush cycle itself still reflect stage LATENCY, because that result has already committed.
- Simultaneous events:
  - flush wins over accept;
  - rst wins over everything;
  - a stalled operation holds; decode must keep its inputs stable until it is accepted.

## Timing
- Reset (synchronous, sampled at posedge clk): all stage v=0 and rd=0, stall_cnt=0. During rst, issue_ready=0, fwd1_sel=fwd2_sel=0, wb_valid=0, wb_rd=0.
- An operation accepted in cycle c has wb_valid asserted in cycle c+LATENCY, aligned with the ALUOut register.
- RAW distance d (the consumer is issued d cycles after the producer):
  - d < LATENCY → stall for LATENCY-d cycles, then forward;
  - d = LATENCY → forward with no stall;
  - d > LATENCY → the register file supplies the value (writeback is assumed to complete by then).
- Back-to-back dependent ALU operations cost LATENCY-1 bubbles (2 with the default).
- All outputs except the stage registers and stall_cnt are combinational from the stage state and the issue inputs. There is no path from flush into the stage data other than the v clear.
- Reset asserted mid-operation: all in-flight operations are discarded. No wb_valid appears for them after reset deasserts.

## Test plan
- Independent stream: issue x1←, x2←, x3← on consecutive cycles, with no shared sources → issue_ready=1 throughout; wb_valid with wb_rd=1,2,3 in cycles 3,4,5 after the first accept; stall_cnt=0.
- Back-to-back RAW: accept rd=5 at cycle 0; next op rs1=5 → issue_ready=0 in cycles 1–2; accepted in cycle 3 with fwd1_sel=1, fwd2_sel=0; stall_cnt=2.
- x0 and unused operand: producer rd=0, consumer rs1=0 → no stall, wb_valid=0. Producer rd=7, consumer rs2=7 with issue_use_rs2=0 → no stall, fwd2_sel=0.
- Youngest-wins: rd=4 accepted at cycles 0 and 2; consumer rs1=4 offered at cycle 3 → stall (stage 1 match) despite the stage-3 match; accepted at cycle 5 with fwd1_sel=1.
- Flush: accept rd=6 at cycles 0 and 1; flush in cycle 2 → wb_valid=0 in cycles 3–4; a consumer rs1=6 offered in cycle 3 is accepted immediately with fwd1_sel=0.
- Reset mid-flight plus saturation: rst in cycle 1 after an accept → no wb_valid afterwards and all outputs 0. With CNT_W=4, hold a stall for 20 cycles → stall_cnt=15.
